chopper_array: RTL and testbench



---
 rtl/chopper_pkg.sv | 26 ++
 rtl/chopper_channel.sv | 135 +++++++++++++
 rtl/chopper_array.sv | 57 +++++
 tb/tb_chopper_array.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chopper_pkg.sv
// Shared types and constants for the per-channel PWM chopper.
// Drive words are packed {l2, l1, h2, h1}.
package chopper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BLANK = 3'd1,
    ST_ON    = 3'd2,
    ST_DECAY = 3'd3,
    ST_FAULT = 3'd4
  } chop_state_t;

  localparam logic [3:0] DRV_OFF   = 4'b0000;
  localparam logic [3:0] DRV_ON_P0 = 4'b1001;  // h1 + l2
  localparam logic [3:0] DRV_ON_P1 = 4'b0110;  // h2 + l1
  localparam logic [3:0] DRV_SLOW  = 4'b1100;  // l1 + l2

  function automatic int strike_w(input int strikes);
    return $clog2(strikes + 1);
  endfunction

  function automatic logic [3:0] drv_on(input logic pol);
    return pol ? DRV_ON_P1 : DRV_ON_P0;
  endfunction

endpackage

// File: rtl/chopper_channel.sv
// One H-bridge chopper: comparator synchroniser, blank/on/decay FSM, timers, drive encode.
// CHOPPER_FASTDECAY_EN enables the leading fast-decay phase; otherwise all decay is slow.
module chopper_channel
  import chopper_pkg::*;
#(
  parameter int OFF_W         = 10,
  parameter int BLANK_W       = 8,
  parameter int MINON_W       = 8,
  parameter int FAULT_STRIKES = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable_in,
  input  logic [OFF_W-1:0]   config_offtime,
  input  logic [OFF_W-1:0]   config_fastdecay_threshold,
  input  logic [BLANK_W-1:0] config_blanktime,
  input  logic [MINON_W-1:0] config_minimum_on_time,
  input  logic               cmp,
  input  logic               polarity,
  output logic [3:0]         drive,
  output logic [2:0]         state_dbg
);

  localparam int SW = strike_w(FAULT_STRIKES);
  localparam logic [SW-1:0] STRIKE_LAST = SW'(FAULT_STRIKES - 1);

  chop_state_t        state;
  logic               cmp_meta, cmp_sync;
  logic               pol, first_on, go_blank;
  logic [BLANK_W-1:0] blank_cnt;
  logic [MINON_W-1:0] minon_cnt;
  logic [OFF_W-1:0]   off_cnt;
  logic [SW-1:0]      strikes;
`ifdef CHOPPER_FASTDECAY_EN
  logic [OFF_W-1:0]   fast_cnt;
`else
  logic               unused_threshold;
  assign unused_threshold = ^config_fastdecay_threshold;
`endif

  assign state_dbg = state;

  // Every path into BLANK shares the same load: counter, latched polarity, on-drive.
  always_comb begin
    go_blank = 1'b0;
    case (state)
      ST_IDLE:         go_blank = 1'b1;
      ST_BLANK, ST_ON: go_blank = (polarity != pol);
      ST_DECAY:        go_blank = (off_cnt <= OFF_W'(1));
      default:         go_blank = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      drive     <= DRV_OFF;
      cmp_meta  <= 1'b0;
      cmp_sync  <= 1'b0;
      pol       <= 1'b0;
      first_on  <= 1'b0;
      blank_cnt <= '0;
      minon_cnt <= '0;
      off_cnt   <= '0;
      strikes   <= '0;
`ifdef CHOPPER_FASTDECAY_EN
      fast_cnt  <= '0;
`endif
    end else begin
      cmp_meta <= cmp;
      cmp_sync <= cmp_meta;
      if (!enable_in) begin
        state    <= ST_IDLE;
        drive    <= DRV_OFF;
        strikes  <= '0;
        first_on <= 1'b0;
      end else if (go_blank) begin
        state     <= ST_BLANK;
        blank_cnt <= config_blanktime;
        pol       <= polarity;
        drive     <= drv_on(polarity);
        first_on  <= 1'b0;
      end else begin
        case (state)
          ST_BLANK: begin
            if (blank_cnt <= BLANK_W'(1)) begin
              state     <= ST_ON;
              minon_cnt <= config_minimum_on_time;
              first_on  <= 1'b1;
            end else begin
              blank_cnt <= blank_cnt - 1'b1;
            end
          end
          ST_ON: begin
            first_on <= 1'b0;
            if (first_on && cmp_sync && strikes == STRIKE_LAST) begin
              state <= ST_FAULT;
              drive <= DRV_OFF;
            end else begin
              if (first_on) strikes <= cmp_sync ? strikes + 1'b1 : '0;
              if (cmp_sync && minon_cnt <= MINON_W'(1)) begin
                state   <= ST_DECAY;
                off_cnt <= config_offtime;
`ifdef CHOPPER_FASTDECAY_EN
                fast_cnt <= config_fastdecay_threshold;
                drive    <= (config_fastdecay_threshold != '0) ? drv_on(~pol) : DRV_SLOW;
`else
                drive    <= DRV_SLOW;
`endif
              end else if (minon_cnt != '0) begin
                minon_cnt <= minon_cnt - 1'b1;
              end
            end
          end
          ST_DECAY: begin
            off_cnt <= off_cnt - 1'b1;
`ifdef CHOPPER_FASTDECAY_EN
            // Drive for the next cycle stays fast while more than one fast cycle remains.
            fast_cnt <= (fast_cnt != '0) ? fast_cnt - 1'b1 : '0;
            drive    <= (fast_cnt > OFF_W'(1)) ? drv_on(~pol) : DRV_SLOW;
`else
            drive    <= DRV_SLOW;
`endif
          end
          ST_FAULT: drive <= DRV_OFF;
          default: begin
            state <= ST_IDLE;
            drive <= DRV_OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/chopper_array.sv
// NCH independent chopper channels; faultn is low while any channel sits in FAULT.
// CHOPPER_FASTDECAY_EN selects the fast-decay build of each channel.
module chopper_array
  import chopper_pkg::*;
#(
  parameter int NCH           = 2,
  parameter int OFF_W         = 10,
  parameter int BLANK_W       = 8,
  parameter int MINON_W       = 8,
  parameter int FAULT_STRIKES = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable_in,
  input  logic [OFF_W-1:0]   config_offtime,
  input  logic [OFF_W-1:0]   config_fastdecay_threshold,
  input  logic [BLANK_W-1:0] config_blanktime,
  input  logic [MINON_W-1:0] config_minimum_on_time,
  input  logic [NCH-1:0]     analog_cmp,
  input  logic [NCH-1:0]     polarity,
  output logic [2*NCH-1:0]   bridge_h,
  output logic [2*NCH-1:0]   bridge_l,
  output logic [NCH-1:0]     chop_active,
  output logic               faultn
);

  logic [3:0]     ch_drive [NCH];
  logic [2:0]     ch_state [NCH];
  logic [NCH-1:0] ch_ok;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    chopper_channel #(
      .OFF_W(OFF_W), .BLANK_W(BLANK_W), .MINON_W(MINON_W), .FAULT_STRIKES(FAULT_STRIKES)
    ) u_ch (
      .clk                        (clk),
      .resetn                     (resetn),
      .enable_in                  (enable_in),
      .config_offtime             (config_offtime),
      .config_fastdecay_threshold (config_fastdecay_threshold),
      .config_blanktime           (config_blanktime),
      .config_minimum_on_time     (config_minimum_on_time),
      .cmp                        (analog_cmp[gi]),
      .polarity                   (polarity[gi]),
      .drive                      (ch_drive[gi]),
      .state_dbg                  (ch_state[gi])
    );

    // State is a register, so these decodes follow the same edge as the drive.
    assign bridge_h[2*gi +: 2] = ch_drive[gi][1:0];
    assign bridge_l[2*gi +: 2] = ch_drive[gi][3:2];
    assign chop_active[gi]     = (ch_state[gi] == ST_BLANK) || (ch_state[gi] == ST_ON);
    assign ch_ok[gi]           = (ch_state[gi] != ST_FAULT);
  end

  assign faultn = &ch_ok;

endmodule

// File: tb/tb_chopper_array.sv
// Self-checking bench for chopper_array: directed scenarios plus random traffic vs. a phase/age model.
module tb_chopper_array;

  localparam int NCH = 2;
  localparam int OFF_W = 10;
  localparam int BLANK_W = 8;
  localparam int MINON_W = 8;
  localparam int FAULT_STRIKES = 3;
`ifdef CHOPPER_FASTDECAY_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif
  localparam int P_IDLE = 0, P_BLANK = 1, P_ON = 2, P_DECAY = 3, P_FAULT = 4;

  logic               clk;
  logic               resetn;
  logic               enable_in;
  logic [OFF_W-1:0]   config_offtime;
  logic [OFF_W-1:0]   config_fastdecay_threshold;
  logic [BLANK_W-1:0] config_blanktime;
  logic [MINON_W-1:0] config_minimum_on_time;
  logic [NCH-1:0]     analog_cmp;
  logic [NCH-1:0]     polarity;
  logic [2*NCH-1:0]   bridge_h;
  logic [2*NCH-1:0]   bridge_l;
  logic [NCH-1:0]     chop_active;
  logic               faultn;

  chopper_array #(
    .NCH(NCH), .OFF_W(OFF_W), .BLANK_W(BLANK_W), .MINON_W(MINON_W), .FAULT_STRIKES(FAULT_STRIKES)
  ) dut (
    .clk                        (clk),
    .resetn                     (resetn),
    .enable_in                  (enable_in),
    .config_offtime             (config_offtime),
    .config_fastdecay_threshold (config_fastdecay_threshold),
    .config_blanktime           (config_blanktime),
    .config_minimum_on_time     (config_minimum_on_time),
    .analog_cmp                 (analog_cmp),
    .polarity                   (polarity),
    .bridge_h                   (bridge_h),
    .bridge_l                   (bridge_l),
    .chop_active                (chop_active),
    .faultn                     (faultn)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: phase plus cycles spent in it, with lengths latched at phase entry.
  int m_ph  [NCH];
  int m_age [NCH];
  int m_len [NCH];
  int m_thr [NCH];
  int m_str [NCH];
  bit m_pol [NCH];
  bit m_c1  [NCH];
  bit m_c2  [NCH];

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic enter_blank(input int c);
    m_ph[c]  = P_BLANK;
    m_age[c] = 0;
    m_len[c] = max1(int'(config_blanktime));
    m_pol[c] = polarity[c];
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit seen;
      seen = m_c2[c];
      m_c2[c] = m_c1[c];
      m_c1[c] = analog_cmp[c];
      if (!resetn) begin
        m_ph[c] = P_IDLE; m_age[c] = 0; m_str[c] = 0; m_pol[c] = 0;
        m_c1[c] = 0; m_c2[c] = 0;
      end else if (!enable_in) begin
        m_ph[c] = P_IDLE; m_str[c] = 0;
      end else if (m_ph[c] == P_IDLE ||
                   ((m_ph[c] == P_BLANK || m_ph[c] == P_ON) && polarity[c] != m_pol[c])) begin
        enter_blank(c);
      end else begin
        case (m_ph[c])
          P_BLANK: begin
            m_age[c]++;
            if (m_age[c] >= m_len[c]) begin
              m_ph[c] = P_ON; m_age[c] = 0; m_len[c] = max1(int'(config_minimum_on_time));
            end
          end
          P_ON: begin
            if (m_age[c] == 0) m_str[c] = seen ? m_str[c] + 1 : 0;
            if (m_str[c] >= FAULT_STRIKES) begin
              m_ph[c] = P_FAULT;
            end else begin
              m_age[c]++;
              if (seen && m_age[c] >= m_len[c]) begin
                m_ph[c]  = P_DECAY;
                m_age[c] = 0;
                m_len[c] = max1(int'(config_offtime));
                m_thr[c] = FAST_EN ? int'(config_fastdecay_threshold) : 0;
              end
            end
          end
          P_DECAY: begin
            m_age[c]++;
            if (m_age[c] >= m_len[c]) enter_blank(c);
          end
          default: ;
        endcase
      end
    end
  endtask

  // Expected {l2, l1, h2, h1} for one channel.
  function automatic logic [3:0] exp_drive(input int c);
    logic [3:0] on_p, on_n;
    on_p = m_pol[c] ? 4'b0110 : 4'b1001;
    on_n = m_pol[c] ? 4'b1001 : 4'b0110;
    case (m_ph[c])
      P_BLANK, P_ON: return on_p;
      P_DECAY:       return (m_age[c] < m_thr[c]) ? on_n : 4'b1100;
      default:       return 4'b0000;
    endcase
  endfunction

  task automatic compare_outputs();
    logic [2*NCH-1:0] eh, el;
    logic [NCH-1:0]   ea;
    logic             ef;
    ef = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      logic [3:0] d;
      d = exp_drive(c);
      eh[2*c +: 2] = d[1:0];
      el[2*c +: 2] = d[3:2];
      ea[c] = (m_ph[c] == P_BLANK) || (m_ph[c] == P_ON);
      if (m_ph[c] == P_FAULT) ef = 1'b0;
    end
    check_eq("bridge_h", bridge_h, eh);
    check_eq("bridge_l", bridge_l, el);
    check_eq("chop_active", chop_active, ea);
    check_eq("faultn", faultn, ef);
  endtask

  // Inputs are settled here; the model steps with what the DUT samples on the next edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  initial begin
    int cnt, nf, ns;
    bit got_fault;

    resetn = 1'b0;
    enable_in = 1'b1;
    config_blanktime = 5;
    config_minimum_on_time = 10;
    config_offtime = 20;
    config_fastdecay_threshold = 0;
    analog_cmp = '0;
    polarity = '0;
    repeat (4) tick();
    check_eq("reset_h", bridge_h, 0);
    check_eq("reset_l", bridge_l, 0);
    check_eq("reset_active", chop_active, 0);
    check_eq("reset_faultn", faultn, 1);
    resetn = 1'b1;

    // Nominal chop: comparator rises well after min-on expired.
    repeat (30) tick();
    analog_cmp[0] = 1'b1;
    tick(); tick();
    check_eq("cmp_latency_on", bridge_l[1:0], 2'b10);
    tick();
    check_eq("cmp_latency_decay", {bridge_h[1:0], bridge_l[1:0]}, 4'b0011);
    analog_cmp[0] = 1'b0;
    cnt = 1;
    repeat (40) begin
      tick();
      if (bridge_h[1:0] == 2'b00 && bridge_l[1:0] == 2'b11) cnt++;
    end
    check_eq("slow_decay_len", cnt, 20);

    // Fast decay split of a 20-cycle decay with threshold 8.
    enable_in = 1'b0; tick();
    enable_in = 1'b1;
    config_fastdecay_threshold = 8;
    repeat (20) tick();
    nf = 0; ns = 0;
    for (int k = 0; k < 45; k++) begin
      analog_cmp[0] = (k < 3);
      tick();
      if (bridge_h[1:0] == 2'b10 && bridge_l[1:0] == 2'b01) nf++;
      if (bridge_h[1:0] == 2'b00 && bridge_l[1:0] == 2'b11) ns++;
    end
    check_eq("fast_cycles", nf, FAST_EN ? 8 : 0);
    check_eq("slow_cycles", ns, FAST_EN ? 12 : 20);

    // Min-on hold on ch1 with comparator high from the start.
    enable_in = 1'b0;
    config_fastdecay_threshold = 0;
    analog_cmp = 2'b10;
    tick(); tick();
    enable_in = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bridge_h[3:2] == 2'b01 && bridge_l[3:2] == 2'b10) cnt++;
      else break;
    end
    check_eq("minon_hold", cnt, 15);

    // Same stuck comparator keeps striking until the channel latches a fault.
    got_fault = 1'b0;
    for (int k = 0; k < 200 && !got_fault; k++) begin
      tick();
      if (!faultn) got_fault = 1'b1;
    end
    check_eq("fault_latched", got_fault, 1'b1);
    check_eq("fault_drive_off", {bridge_h[3:2], bridge_l[3:2]}, 4'b0000);
    repeat (5) tick();
    check_eq("fault_sticky", faultn, 1'b0);
    enable_in = 1'b0; tick();
    check_eq("fault_cleared", faultn, 1'b1);
    check_eq("fault_idle", chop_active, 2'b00);
    analog_cmp = '0;

    // Polarity flip on ch0 during ON cycle 4.
    enable_in = 1'b1;
    polarity = '0;
    repeat (9) tick();
    polarity[0] = 1'b1;
    tick();
    check_eq("flip_ch0_h", bridge_h[1:0], 2'b10);
    check_eq("flip_ch0_l", bridge_l[1:0], 2'b01);
    check_eq("flip_ch1_h", bridge_h[3:2], 2'b01);
    repeat (6) tick();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        config_blanktime = BLANK_W'($urandom_range(0, 6));
        config_minimum_on_time = MINON_W'($urandom_range(0, 8));
        config_offtime = OFF_W'($urandom_range(0, 12));
        config_fastdecay_threshold = OFF_W'($urandom_range(0, 14));
      end
      for (int c = 0; c < NCH; c++) begin
        analog_cmp[c] = ($urandom_range(0, 99) < 25);
        if ($urandom_range(0, 59) == 0) polarity[c] = ~polarity[c];
      end
      enable_in = ($urandom_range(0, 199) != 0);
      resetn = ($urandom_range(0, 999) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
